// File: rtl/prewitt_window_ctrl.sv
// Line-buffer front end for the 3x3 Prewitt datapath: turns a raster pixel stream into three
// vertically aligned row taps plus a window-valid strobe, with position tracking and framing.
module prewitt_window_ctrl #(
  parameter int unsigned PIC_WIDTH  = 480,
  parameter int unsigned PIC_HEIGHT = 272,
  parameter int unsigned DW         = 8,
  parameter int unsigned CW         = 9,
  parameter int unsigned RW         = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sof_i,
  input  logic          pix_valid_i,
  input  logic [DW-1:0] pix_data_i,
  output logic [DW-1:0] row_top_o,
  output logic [DW-1:0] row_mid_o,
  output logic [DW-1:0] row_bot_o,
  output logic          win_valid_o,
  output logic          border_o,
  output logic [CW-1:0] col_cnt_o,
  output logic [RW-1:0] row_cnt_o,
  output logic          frame_done_o,
  output logic          sync_err_o
);

  localparam logic [CW-1:0] ColLast = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(PIC_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StPrime, StActive} state_e;

  state_e state_q, state_d;

  // Position of the next pixel expected in the raster
  logic [CW-1:0] nxt_col_q, nxt_col_d;
  logic [RW-1:0] nxt_row_q, nxt_row_d;

  // LB1 holds the previous line, LB0 the line before that
  logic [DW-1:0] lb0_q [PIC_WIDTH];
  logic [DW-1:0] lb1_q [PIC_WIDTH];

  logic [DW-1:0] row_top_q, row_mid_q, row_bot_q;
  logic [CW-1:0] col_cnt_q;
  logic [RW-1:0] row_cnt_q;
  logic          win_valid_q, border_q, frame_done_q, sync_err_q;

  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          last_col, last_row, prime_end, frame_end, row_ge2;

  // Decode acceptance and the position of the pixel being accepted this cycle
  always_comb begin
    accept    = pix_valid_i & (sof_i | (state_q != StIdle));
    // sof restarts the raster with this very pixel
    cur_col   = sof_i ? '0 : nxt_col_q;
    cur_row   = sof_i ? '0 : nxt_row_q;
    last_col  = (cur_col == ColLast);
    last_row  = (cur_row == RowLast);
    prime_end = last_col & (cur_row == RW'(1));
    frame_end = last_col & last_row;
    row_ge2   = (cur_row >= RW'(2));
  end

  // Next-state and next-position logic
  always_comb begin
    state_d   = state_q;
    nxt_col_d = nxt_col_q;
    nxt_row_d = nxt_row_q;
    if (accept) begin
      if (last_col) begin
        nxt_col_d = '0;
        nxt_row_d = last_row ? '0 : cur_row + RW'(1);
      end else begin
        nxt_col_d = cur_col + CW'(1);
        nxt_row_d = cur_row;
      end
    end
    case (state_q)
      StIdle: begin
        if (accept) state_d = StPrime;
      end
      StPrime: begin
        if (accept && !sof_i && prime_end) state_d = StActive;
      end
      StActive: begin
        if (accept && sof_i)          state_d = StPrime;
        else if (accept && frame_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      nxt_col_q <= '0;
      nxt_row_q <= '0;
    end else begin
      state_q   <= state_d;
      nxt_col_q <= nxt_col_d;
      nxt_row_q <= nxt_row_d;
    end
  end

  // Line buffers: read-before-write at the same column shifts the column up one line
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= pix_data_i;
    end
  end

  // Registered taps, position and strobes; taps and position hold without acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_top_q    <= '0;
      row_mid_q    <= '0;
      row_bot_q    <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      win_valid_q  <= 1'b0;
      border_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        row_top_q <= lb0_q[cur_col];
        row_mid_q <= lb1_q[cur_col];
        row_bot_q <= pix_data_i;
        col_cnt_q <= cur_col;
        row_cnt_q <= cur_row;
      end
      win_valid_q  <= accept & row_ge2;
      border_q     <= accept & row_ge2 & (cur_col < CW'(2));
      frame_done_q <= accept & frame_end;
      sync_err_q   <= accept & sof_i & (state_q != StIdle);
    end
  end

  assign row_top_o    = row_top_q;
  assign row_mid_o    = row_mid_q;
  assign row_bot_o    = row_bot_q;
  assign col_cnt_o    = col_cnt_q;
  assign row_cnt_o    = row_cnt_q;
  assign win_valid_o  = win_valid_q;
  assign border_o     = border_q;
  assign frame_done_o = frame_done_q;
  assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_prewitt_window_ctrl.sv
// Self-checking bench for prewitt_window_ctrl on a small 8x6 frame. A frame-image model
// predicts every output cycle from raster position arithmetic.
module tb_prewitt_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int CW = 3;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof_i = 1'b0;
  logic          pix_valid_i = 1'b0;
  logic [DW-1:0] pix_data_i = '0;
  logic [DW-1:0] row_top_o, row_mid_o, row_bot_o;
  logic          win_valid_o, border_o, frame_done_o, sync_err_o;
  logic [CW-1:0] col_cnt_o;
  logic [RW-1:0] row_cnt_o;

  prewitt_window_ctrl #(
    .PIC_WIDTH (W),
    .PIC_HEIGHT(H),
    .DW        (DW),
    .CW        (CW),
    .RW        (RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sof_i       (sof_i),
    .pix_valid_i (pix_valid_i),
    .pix_data_i  (pix_data_i),
    .row_top_o   (row_top_o),
    .row_mid_o   (row_mid_o),
    .row_bot_o   (row_bot_o),
    .win_valid_o (win_valid_o),
    .border_o    (border_o),
    .col_cnt_o   (col_cnt_o),
    .row_cnt_o   (row_cnt_o),
    .frame_done_o(frame_done_o),
    .sync_err_o  (sync_err_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: raster index within the frame plus the image seen so far
  bit            m_active;
  int            m_idx;
  logic [DW-1:0] img [H][W];
  logic [DW-1:0] e_top, e_mid, e_bot;
  int            e_col, e_row;
  bit            e_win, e_border, e_done, e_sync, taps_known;

  task automatic model_reset();
    m_active = 0; m_idx = 0;
    e_top = '0; e_mid = '0; e_bot = '0; e_col = 0; e_row = 0;
    e_win = 0; e_border = 0; e_done = 0; e_sync = 0; taps_known = 1;
  endtask

  // Apply one cycle of stimulus, advance the model, and land 1 time unit after the edge
  task automatic drive(input bit s, input bit v, input logic [DW-1:0] d);
    int r, c;
    sof_i = s; pix_valid_i = v; pix_data_i = d;
    e_win = 0; e_border = 0; e_done = 0; e_sync = 0;
    if (v && (s || m_active)) begin
      if (s) begin
        e_sync = m_active;
        m_idx  = 0;
      end
      r = m_idx / W;
      c = m_idx % W;
      img[r][c] = d;
      e_bot = d; e_col = c; e_row = r;
      if (r >= 2) begin
        e_top = img[r-2][c];
        e_mid = img[r-1][c];
        taps_known = 1;
        e_win = 1;
        e_border = (c < 2);
      end else begin
        taps_known = 0;
      end
      e_done   = (m_idx == W * H - 1);
      m_active = !e_done;
      m_idx    = e_done ? 0 : m_idx + 1;
    end
    @(posedge clk);
    #1;
    sof_i = 1'b0; pix_valid_i = 1'b0;
  endtask

  function automatic logic [33:0] obs_vec();
    return {taps_known ? {row_top_o, row_mid_o} : 16'h0, row_bot_o, col_cnt_o, row_cnt_o,
            win_valid_o, border_o, frame_done_o, sync_err_o};
  endfunction

  function automatic logic [33:0] exp_vec();
    return {taps_known ? {e_top, e_mid} : 16'h0, e_bot, CW'(e_col), RW'(e_row),
            e_win, e_border, e_done, e_sync};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    // pix_valid without sof straight after reset is ignored
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, DW'($urandom));
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL idle_after_reset %0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  // Continuous ramp frame pix = row*16 + col
  task automatic test_ramp_frame();
    int  wins = 0, dones = 0;
    bit  first = 1;
    for (int i = 0; i < W * H; i++) begin
      drive(i == 0, 1'b1, DW'((i / W) * 16 + (i % W)));
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL ramp idx=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (win_valid_o) wins++;
      if (frame_done_o) begin
        dones++;
        n_total++;
        if ({row_cnt_o, col_cnt_o} !== {RW'(5), CW'(7)})
          $display("FAIL ramp_done_pos: got r%0d c%0d want r5 c7", row_cnt_o, col_cnt_o);
        else n_pass++;
      end
      if (win_valid_o && first) begin
        first = 0;
        n_total++;
        if ({row_top_o, row_mid_o, row_bot_o, row_cnt_o, col_cnt_o} !==
            {8'h00, 8'h10, 8'h20, RW'(2), CW'(0)})
          $display("FAIL ramp_first_win: got %h %h %h r%0d c%0d want 00 10 20 r2 c0",
                   row_top_o, row_mid_o, row_bot_o, row_cnt_o, col_cnt_o);
        else n_pass++;
      end
    end
    n_total++;
    if (wins !== 32 || dones !== 1)
      $display("FAIL ramp_counts: got wins=%0d dones=%0d want 32 1", wins, dones);
    else n_pass++;
  endtask

  // Same ramp frame with pix_valid toggling 1/0
  task automatic test_gaps();
    int wins = 0, dones = 0;
    for (int i = 0; i < W * H; i++) begin
      drive(i == 0, 1'b1, DW'((i / W) * 16 + (i % W)));
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL gaps_pix idx=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (win_valid_o) wins++;
      if (frame_done_o) dones++;
      drive(1'b0, 1'b0, DW'($urandom));
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL gaps_hold idx=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if (wins !== 32 || dones !== 1)
      $display("FAIL gaps_counts: got wins=%0d dones=%0d want 32 1", wins, dones);
    else n_pass++;
  endtask

  // Border strobe checked directly against raster position, random data
  task automatic test_border();
    bit exp_b;
    for (int i = 0; i < W * H; i++) begin
      drive(i == 0, 1'b1, DW'($urandom));
      exp_b = ((i / W) >= 2) && ((i % W) < 2);
      n_total++;
      if (border_o !== exp_b || obs_vec() !== exp_vec())
        $display("FAIL border idx=%0d: got b=%0b vec %h want b=%0b vec %h",
                 i, border_o, obs_vec(), exp_b, exp_vec());
      else n_pass++;
    end
  endtask

  // sof arriving at (3,4) aborts the frame and restarts the raster
  task automatic test_sync_abort();
    int syncs = 0, dones = 0;
    for (int i = 0; i < 28 + W * H; i++) begin
      drive(i == 0 || i == 28, 1'b1, DW'($urandom));
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL abort idx=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (sync_err_o) syncs++;
      if (frame_done_o) dones++;
      if (i == 28) begin
        n_total++;
        if ({sync_err_o, row_cnt_o, col_cnt_o, win_valid_o} !== {1'b1, RW'(0), CW'(0), 1'b0})
          $display("FAIL abort_restart: got s%0b r%0d c%0d w%0b want s1 r0 c0 w0",
                   sync_err_o, row_cnt_o, col_cnt_o, win_valid_o);
        else n_pass++;
      end
      if (i == 27 + W * H - 1) begin
        n_total++;
        if (dones !== 0) $display("FAIL abort_no_done: got %0d want 0", dones);
        else n_pass++;
      end
    end
    n_total++;
    if (syncs !== 1 || dones !== 1)
      $display("FAIL abort_counts: got syncs=%0d dones=%0d want 1 1", syncs, dones);
    else n_pass++;
  endtask

  // After frame_done, pix_valid without sof changes nothing
  task automatic test_ignore_idle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, DW'($urandom));
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL idle_after_done %0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  // Random data and random gap lengths over a whole frame
  task automatic test_random();
    for (int i = 0; i < W * H; i++) begin
      drive(i == 0, 1'b1, DW'($urandom));
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random idx=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      repeat ($urandom_range(0, 2)) begin
        drive(1'b0, 1'b0, DW'($urandom));
        n_total++;
        if (obs_vec() !== exp_vec())
          $display("FAIL random_gap idx=%0d: got %h want %h", i, obs_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  // Reset asserted during row 3, then a fresh frame must match the ramp results
  task automatic test_reset_midframe();
    for (int i = 0; i < 26; i++) drive(i == 0, 1'b1, DW'(i));
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (obs_vec() !== exp_vec())
      $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_ramp_frame();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp_frame();
    test_ignore_idle();
    test_gaps();
    test_border();
    test_sync_abort();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
